// File: rtl/bt_pipe_pkg.sv
// Shared types and constants for the block-throttled input pipe controller.
package bt_pipe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int NERR        = 3;
    localparam int ERR_STRAY   = 0;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_SHORT   = 2;

    localparam int DEF_BLOCK_WORDS = 256;
    localparam int DEF_DEPTH       = 1024;

endpackage

// File: rtl/bt_pipe_in_ctrl_if.sv
// Endpoint write side plus downstream valid/ready stream.
interface bt_pipe_in_ctrl_if;

    logic        ep_write;
    logic        ep_blockstrobe;
    logic [31:0] ep_dataout;
    logic        ep_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    modport master (
        output ep_write,
        output ep_blockstrobe,
        output ep_dataout,
        input  ep_ready,
        input  dout,
        input  dout_valid,
        output dout_ready
    );

    modport slave (
        input  ep_write,
        input  ep_blockstrobe,
        input  ep_dataout,
        output ep_ready,
        output dout,
        output dout_valid,
        input  dout_ready
    );

endinterface

// File: rtl/bt_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy and look-ahead count.
module bt_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [AW:0]   count_nxt
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/bt_pipe_in_ctrl.sv
// Block framing, flow control and error reporting for the input pipe.
module bt_pipe_in_ctrl
    import bt_pipe_pkg::*;
#(
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic              ti_clk,
    input  logic              ti_reset,
    bt_pipe_in_ctrl_if.slave  pipe,
    output logic [AW:0]       fill,
    output logic [15:0]       blocks_done,
    output logic              in_block,
    output logic              err_stray,
    output logic              err_overrun,
    output logic              err_short,
    input  logic              err_clear
);

    localparam int          WCW    = $clog2(BLOCK_WORDS + 1);
    localparam logic [WCW-1:0] LAST = WCW'(BLOCK_WORDS - 1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] BLK_C   = (AW+1)'(BLOCK_WORDS);

    state_t          state, state_nxt;
    logic [WCW-1:0]  wcnt, wcnt_nxt;
    logic [NERR-1:0] err_q, err_set;
    logic            done;
    logic            push;
    logic            full;
    logic            empty;
    logic [AW:0]     fill_nxt;
    logic [AW:0]     free_nxt;

    assign push     = pipe.ep_write && (state == RECV);
    assign free_nxt = DEPTH_C - fill_nxt;

    bt_sync_fifo #(
        .W     (32),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (ti_clk),
        .rst       (ti_reset),
        .wr_en     (push),
        .wr_data   (pipe.ep_dataout),
        .rd_en     (pipe.dout_ready),
        .rd_data   (pipe.dout),
        .full      (full),
        .empty     (empty),
        .count     (fill),
        .count_nxt (fill_nxt)
    );

    assign pipe.dout_valid = !empty;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        done      = 1'b0;
        err_set   = '0;
        unique case (state)
            IDLE: begin
                if (pipe.ep_write) err_set[ERR_STRAY] = 1'b1;
                if (pipe.ep_blockstrobe) begin
                    state_nxt = RECV;
                    wcnt_nxt  = '0;
                end
            end
            RECV: begin
                // Dropped words still count: framing follows the host.
                if (pipe.ep_write) begin
                    wcnt_nxt = wcnt + WCW'(1);
                    if (full) err_set[ERR_OVERRUN] = 1'b1;
                    if (wcnt == LAST) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                if (pipe.ep_blockstrobe) begin
                    err_set[ERR_SHORT] = 1'b1;
                    wcnt_nxt  = '0;
                    state_nxt = RECV;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ti_clk) begin
        if (ti_reset) begin
            state         <= IDLE;
            wcnt          <= '0;
            blocks_done   <= '0;
            pipe.ep_ready <= 1'b0;
            err_q         <= '0;
        end else begin
            state         <= state_nxt;
            wcnt          <= wcnt_nxt;
            if (done) blocks_done <= blocks_done + 16'd1;
            pipe.ep_ready <= (state_nxt == IDLE) && (free_nxt >= BLK_C);
            err_q         <= (err_q & ~{NERR{err_clear}}) | err_set;
        end
    end

    assign in_block    = (state == RECV);
    assign err_stray   = err_q[ERR_STRAY];
    assign err_overrun = err_q[ERR_OVERRUN];
    assign err_short   = err_q[ERR_SHORT];

endmodule

// File: tb/tb_bt_pipe_in_ctrl.sv
// Directed bench for bt_pipe_in_ctrl: a 4/8 instance and an 8/8 instance.
module tb_bt_pipe_in_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic eclr_a, eclr_b;
    logic [3:0]  fill_a, fill_b;
    logic [15:0] bd_a, bd_b;
    logic inb_a, es_a, eo_a, esh_a;
    logic inb_b, es_b, eo_b, esh_b;
    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    bt_pipe_in_ctrl_if ia ();
    bt_pipe_in_ctrl_if ib ();

    bt_pipe_in_ctrl #(.BLOCK_WORDS(4), .DEPTH(8)) dut_a (
        .ti_clk(clk), .ti_reset(rst), .pipe(ia.slave),
        .fill(fill_a), .blocks_done(bd_a), .in_block(inb_a),
        .err_stray(es_a), .err_overrun(eo_a), .err_short(esh_a),
        .err_clear(eclr_a)
    );

    bt_pipe_in_ctrl #(.BLOCK_WORDS(8), .DEPTH(8)) dut_b (
        .ti_clk(clk), .ti_reset(rst), .pipe(ib.slave),
        .fill(fill_b), .blocks_done(bd_b), .in_block(inb_b),
        .err_stray(es_b), .err_overrun(eo_b), .err_short(esh_b),
        .err_clear(eclr_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic blk_a(input logic [31:0] base, input int n);
        ia.ep_blockstrobe = 1'b1;
        step();
        ia.ep_blockstrobe = 1'b0;
        for (int i = 0; i < n; i++) begin
            ia.ep_write   = 1'b1;
            ia.ep_dataout = base + 32'(i);
            step();
        end
        ia.ep_write = 1'b0;
    endtask

    task automatic test_reset();
        if ({ia.ep_ready, ia.dout_valid, fill_a, bd_a, inb_a} !== 23'd0)
            $display("FAIL rst_a_outs got=%b exp=0",
                     {ia.ep_ready, ia.dout_valid, fill_a, bd_a, inb_a});
        else npass++;
        ntot++;
        if ({es_a, eo_a, esh_a} !== 3'b000)
            $display("FAIL rst_a_err got=%b exp=000", {es_a, eo_a, esh_a});
        else npass++;
        ntot++;
        rst = 1'b0;
        step();
        if (ia.ep_ready !== 1'b1)
            $display("FAIL rst_a_rdy got=%b exp=1", ia.ep_ready);
        else npass++;
        ntot++;
    endtask

    task automatic test_basic();
        ia.dout_ready = 1'b1;
        ia.ep_blockstrobe = 1'b1;
        step();
        ia.ep_blockstrobe = 1'b0;
        if ({ia.ep_ready, inb_a} !== 2'b01)
            $display("FAIL basic_strobe rdy/inb got=%b exp=01", {ia.ep_ready, inb_a});
        else npass++;
        ntot++;
        for (int i = 0; i < 4; i++) begin
            ia.ep_write   = 1'b1;
            ia.ep_dataout = 32'hA0 + 32'(i);
            step();
            if ({ia.dout_valid, ia.dout} !== {1'b1, 32'hA0 + 32'(i)})
                $display("FAIL basic_dout%0d got=%b/%h exp=1/%h",
                         i, ia.dout_valid, ia.dout, 32'hA0 + 32'(i));
            else npass++;
            ntot++;
            if ({ia.ep_ready, fill_a} !== {(i == 3), 4'd1})
                $display("FAIL basic_rdy_fill%0d got=%b/%0d exp=%b/1",
                         i, ia.ep_ready, fill_a, (i == 3));
            else npass++;
            ntot++;
        end
        ia.ep_write = 1'b0;
        if ({bd_a, inb_a} !== {16'd1, 1'b0})
            $display("FAIL basic_done got=%0d/%b exp=1/0", bd_a, inb_a);
        else npass++;
        ntot++;
        step();
        if ({ia.dout_valid, fill_a} !== 5'd0)
            $display("FAIL basic_drain got=%b/%0d exp=0/0", ia.dout_valid, fill_a);
        else npass++;
        ntot++;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q [8];
        exp_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3,
                  32'hC0, 32'hC1, 32'hC2, 32'hC3};
        ia.dout_ready = 1'b0;
        blk_a(32'hB0, 4);
        if ({ia.ep_ready, fill_a} !== {1'b1, 4'd4})
            $display("FAIL bp_blk1 got=%b/%0d exp=1/4", ia.ep_ready, fill_a);
        else npass++;
        ntot++;
        blk_a(32'hC0, 4);
        if ({ia.ep_ready, fill_a, es_a, eo_a, esh_a} !== {1'b0, 4'd8, 3'b000})
            $display("FAIL bp_blk2 got=%b/%0d/%b exp=0/8/000",
                     ia.ep_ready, fill_a, {es_a, eo_a, esh_a});
        else npass++;
        ntot++;
        for (int k = 0; k < 8; k++) begin
            if (ia.dout !== exp_q[k])
                $display("FAIL bp_order%0d got=%h exp=%h", k, ia.dout, exp_q[k]);
            else npass++;
            ntot++;
            ia.dout_ready = 1'b1;
            step();
            ia.dout_ready = 1'b0;
            if (k == 2) begin
                if ({ia.ep_ready, fill_a} !== {1'b0, 4'd5})
                    $display("FAIL bp_pop3 got=%b/%0d exp=0/5", ia.ep_ready, fill_a);
                else npass++;
                ntot++;
            end
            if (k == 3) begin
                if ({ia.ep_ready, fill_a} !== {1'b1, 4'd4})
                    $display("FAIL bp_pop4 got=%b/%0d exp=1/4", ia.ep_ready, fill_a);
                else npass++;
                ntot++;
            end
        end
        if ({fill_a, bd_a} !== {4'd0, 16'd3})
            $display("FAIL bp_end got=%0d/%0d exp=0/3", fill_a, bd_a);
        else npass++;
        ntot++;
    endtask

    task automatic test_short();
        blk_a(32'hD0, 2);
        blk_a(32'hD2, 4);
        if ({esh_a, bd_a, fill_a, inb_a, ia.ep_ready} !== {1'b1, 16'd4, 4'd6, 2'b00})
            $display("FAIL short_state got=%b/%0d/%0d/%b/%b exp=1/4/6/0/0",
                     esh_a, bd_a, fill_a, inb_a, ia.ep_ready);
        else npass++;
        ntot++;
        ia.dout_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (ia.dout !== 32'hD0 + 32'(k))
                $display("FAIL short_data%0d got=%h exp=%h", k, ia.dout, 32'hD0 + 32'(k));
            else npass++;
            ntot++;
            step();
        end
        ia.dout_ready = 1'b0;
        eclr_a = 1'b1;
        step();
        eclr_a = 1'b0;
        if ({esh_a, fill_a} !== 5'd0)
            $display("FAIL short_clear got=%b/%0d exp=0/0", esh_a, fill_a);
        else npass++;
        ntot++;
    endtask

    task automatic test_stray();
        ia.ep_write   = 1'b1;
        ia.ep_dataout = 32'hDEAD;
        step();
        ia.ep_write = 1'b0;
        if ({es_a, fill_a, inb_a} !== {1'b1, 4'd0, 1'b0})
            $display("FAIL stray_set got=%b/%0d/%b exp=1/0/0", es_a, fill_a, inb_a);
        else npass++;
        ntot++;
        eclr_a = 1'b1;
        step();
        eclr_a = 1'b0;
        if (es_a !== 1'b0)
            $display("FAIL stray_clear got=%b exp=0", es_a);
        else npass++;
        ntot++;
        eclr_a      = 1'b1;
        ia.ep_write = 1'b1;
        step();
        eclr_a      = 1'b0;
        ia.ep_write = 1'b0;
        if (es_a !== 1'b1)
            $display("FAIL stray_prio got=%b exp=1", es_a);
        else npass++;
        ntot++;
        eclr_a = 1'b1;
        step();
        eclr_a = 1'b0;
    endtask

    task automatic test_overrun();
        ib.dout_ready     = 1'b0;
        ib.ep_blockstrobe = 1'b1;
        step();
        ib.ep_blockstrobe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ib.ep_write   = 1'b1;
            ib.ep_dataout = 32'hE0 + 32'(i);
            step();
        end
        ib.ep_write = 1'b0;
        if ({fill_b, bd_b, ib.ep_ready, eo_b} !== {4'd8, 16'd1, 2'b00})
            $display("FAIL ovr_fill got=%0d/%0d/%b/%b exp=8/1/0/0",
                     fill_b, bd_b, ib.ep_ready, eo_b);
        else npass++;
        ntot++;
        ib.ep_blockstrobe = 1'b1;
        step();
        ib.ep_blockstrobe = 1'b0;
        ib.ep_write   = 1'b1;
        ib.ep_dataout = 32'hE8;
        step();
        ib.ep_write = 1'b0;
        if ({eo_b, fill_b, es_b, inb_b} !== {1'b1, 4'd8, 2'b01})
            $display("FAIL ovr_drop got=%b/%0d/%b/%b exp=1/8/0/1",
                     eo_b, fill_b, es_b, inb_b);
        else npass++;
        ntot++;
        if (ib.dout !== 32'hE0)
            $display("FAIL ovr_head got=%h exp=e0", ib.dout);
        else npass++;
        ntot++;
    endtask

    task automatic test_reset_mid();
        ia.dout_ready = 1'b0;
        blk_a(32'hF0, 2);
        if ({fill_a, inb_a} !== {4'd2, 1'b1})
            $display("FAIL mid_pre got=%0d/%b exp=2/1", fill_a, inb_a);
        else npass++;
        ntot++;
        rst = 1'b1;
        step();
        if ({fill_a, ia.dout_valid, inb_a, ia.ep_ready, bd_a} !== 23'd0)
            $display("FAIL mid_rst got=%0d/%b/%b/%b/%0d exp=0/0/0/0/0",
                     fill_a, ia.dout_valid, inb_a, ia.ep_ready, bd_a);
        else npass++;
        ntot++;
        rst = 1'b0;
        step();
        if (ia.ep_ready !== 1'b1)
            $display("FAIL mid_release got=%b exp=1", ia.ep_ready);
        else npass++;
        ntot++;
    endtask

    initial begin
        rst = 1'b1;
        eclr_a = 1'b0;
        eclr_b = 1'b0;
        ia.ep_write = 1'b0; ia.ep_blockstrobe = 1'b0;
        ia.ep_dataout = '0; ia.dout_ready = 1'b0;
        ib.ep_write = 1'b0; ib.ep_blockstrobe = 1'b0;
        ib.ep_dataout = '0; ib.dout_ready = 1'b0;
        step();
        step();
        test_reset();
        test_basic();
        test_backpressure();
        test_short();
        test_stray();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
